bel_fft_sif_arb: RTL and testbench
==================================

Name: bel_fft_sif_arb

Overview:
Two-master arbiter that shares the single internal FFT slave register interface between two Avalon-MM masters, e.g. the Nios data master and a DMA/config sequencer. Each master sees an Avalon-MM slave port with waitrequest and readdatavalid. The arbiter serialises accesses round-robin and drives the internal adr/dat/bsel/rd/wr strobes, holding them until ack_i or err_i arrives. A timeout guarantees forward progress if the FFT core never acknowledges.

Parameters:
AWIDTH, 8, address width of the masters and the internal interface
DWIDTH, 32, data width
BCNT, 4, byte-enable width (DWIDTH/8)
TIMEOUT, 64, cycles in BUSY without ack/err before forced completion; 0 disables the timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
m0_address/m1_address  in  AWIDTH  master address
m0_writedata/m1_writedata  in  DWIDTH  write data
m0_byteenable/m1_byteenable  in  BCNT  byte enables
m0_read/m1_read  in  1  read request
m0_write/m1_write  in  1  write request
m0_waitrequest/m1_waitrequest  out  1  low in the cycle the request is accepted
m0_readdata/m1_readdata  out  DWIDTH  registered read response
m0_readdatavalid/m1_readdatavalid  out  1  one-cycle response strobe
adr_o  out  AWIDTH  internal address
dat_o  out  DWIDTH  internal write data
bsel_o  out  BCNT  internal byte select
rd_o  out  1  internal read strobe
wr_o  out  1  internal write strobe
dat_i  in  DWIDTH  internal read data
ack_i  in  1  internal completion
err_i  in  1  internal error completion
busy_o  out  1  high while in BUSY
err_o  out  1  one-cycle pulse on err_i or timeout completion
err_src_o  out  1  master index of the last errored transaction

Behaviour:
- Reset values: all outputs 0. The only exception is waitrequest, which follows its combinational rule below. State is IDLE and last_grant is 1, so master 0 wins the first tie.
- Request: reqN = mN_read | mN_write. If read and write are both high, the access is treated as a write (illegal input per Avalon).
- IDLE state: if any reqN is high, select the grant:
  - only one master requesting: that master wins;
  - both requesting: the master that is not last_grant wins.
- Acceptance (IDLE cycle with a request):
  - granted master's waitrequest is 0 combinationally that cycle; every other requester sees waitrequest 1;
  - address, writedata, byteenable and operation are registered into adr_o/dat_o/bsel_o and rd_o or wr_o;
  - last_grant is updated and state goes to BUSY.
- Outside IDLE, both waitrequest outputs are 1 whenever the matching req is high. Waitrequest is 0 when there is no request.
- BUSY state:
  - rd_o/wr_o, adr_o, dat_o and bsel_o are held stable;
  - the timeout counter starts at 0 on entry and increments each BUSY cycle.
- Completion occurs on ack_i, err_i, or the counter reaching TIMEOUT-1 with TIMEOUT>0.
  - On that edge: rd_o/wr_o go to 0, state goes to IDLE.
  - For a read: the granted mN_readdata is loaded and mN_readdatavalid pulses for exactly one cycle (the cycle after completion). Loaded data is dat_i on ack, and all ones on err or timeout.
  - For a write: no response strobe; writes are posted.
  - On err or timeout: err_o pulses one cycle and err_src_o is loaded with the granted index.
- Priority in the same cycle: err_i over ack_i; ack/err over timeout in the final count cycle. ack_i/err_i received in IDLE are ignored.
- Latency: accept at T0, strobe at T1; with ack at T1, readdatavalid at T2. The next accept can occur at T2, giving a minimum of 2 cycles per access.
- readdata holds its value until the next read response to the same master.
- Reset mid-transaction: strobes drop the next edge, the pending response is discarded (no readdatavalid), and last_grant returns to 1.

Test Plan:
- Single read by m0 at address 0x10, ack at T1 with dat_i 0xA5A5_0001 -> rd_o high T1 only, m0_readdatavalid high T2, m0_readdata 0xA5A5_0001, m1 outputs unchanged.
- Both masters request at T0 (m0 write 0x1234 to 0x04, m1 read 0x08), ack immediate each time -> m0 accepted T0, m1 waitrequest 1 until accepted T2. A second simultaneous pair is then granted m1 before m0 if m1 was not the last granted, alternating with no starvation.
- m1 read, ack delayed 5 cycles -> rd_o and adr_o stable for 5 cycles, busy_o 1, m0 request stalled by waitrequest throughout, readdatavalid 1 cycle after ack.
- TIMEOUT=8, m0 read, no ack -> completion after 8 BUSY cycles, m0_readdata 0xFFFF_FFFF with valid pulse, err_o pulse, err_src_o 0.
- err_i and ack_i together on an m1 read -> all-ones data, err_o pulse, err_src_o 1.
- rst_i asserted in BUSY with ack pending -> rd_o/wr_o 0 the next cycle, no readdatavalid, and a subsequent simultaneous request is granted to m0.

Source files
------------

// File: rtl/bel_fft_sif_arb.sv
// Round-robin arbiter sharing the FFT core's internal register bus between two
// Avalon-MM masters; each access completes on ack_i, err_i or a timeout.
module bel_fft_sif_arb #(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 32,
    parameter int BCNT    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic [AWIDTH-1:0] m0_address,
    input  logic [DWIDTH-1:0] m0_writedata,
    input  logic [BCNT-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    output logic              m0_waitrequest,
    output logic [DWIDTH-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [AWIDTH-1:0] m1_address,
    input  logic [DWIDTH-1:0] m1_writedata,
    input  logic [BCNT-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    output logic              m1_waitrequest,
    output logic [DWIDTH-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [AWIDTH-1:0] adr_o,
    output logic [DWIDTH-1:0] dat_o,
    output logic [BCNT-1:0]   bsel_o,
    output logic              rd_o,
    output logic              wr_o,
    input  logic [DWIDTH-1:0] dat_i,
    input  logic              ack_i,
    input  logic              err_i,

    output logic              busy_o,
    output logic              err_o,
    output logic              err_src_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit              TO_EN    = (TIMEOUT > 0);
    localparam logic [CW-1:0]   CNT_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic [AWIDTH-1:0] adr_q, adr_d;
    logic [DWIDTH-1:0] dat_q, dat_d;
    logic [BCNT-1:0]   bsel_q, bsel_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DWIDTH-1:0] rdata0_q, rdata0_d;
    logic [DWIDTH-1:0] rdata1_q, rdata1_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic              err_q, err_d;
    logic              err_src_q, err_src_d;

    logic              req0, req1;
    logic              grant_sel;
    logic              accept;
    logic              timeout_hit;
    logic              done;
    logic              failed;
    logic [DWIDTH-1:0] resp_data;

    logic [AWIDTH-1:0] sel_adr;
    logic [DWIDTH-1:0] sel_dat;
    logic [BCNT-1:0]   sel_bsel;
    logic              sel_rd;
    logic              sel_wr;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // On a tie the master that was not served last wins; otherwise the sole requester.
    assign grant_sel = (req0 && req1) ? ~last_grant_q : req1;
    assign accept    = (state_q == IDLE) && (req0 || req1);

    assign sel_adr  = grant_sel ? m1_address    : m0_address;
    assign sel_dat  = grant_sel ? m1_writedata  : m0_writedata;
    assign sel_bsel = grant_sel ? m1_byteenable : m0_byteenable;
    assign sel_rd   = grant_sel ? m1_read       : m0_read;
    assign sel_wr   = grant_sel ? m1_write      : m0_write;

    assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);
    assign done        = (state_q == BUSY) && (ack_i || err_i || timeout_hit);
    // err_i outranks ack_i; a timeout only counts when neither arrived.
    assign failed      = err_i || !ack_i;
    assign resp_data   = failed ? '1 : dat_i;

    assign m0_waitrequest = req0 & ~(accept & ~grant_sel);
    assign m1_waitrequest = req1 & ~(accept &  grant_sel);

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        bsel_d       = bsel_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        cnt_d        = cnt_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        err_d        = 1'b0;
        err_src_d    = err_src_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = BUSY;
                    grant_d      = grant_sel;
                    last_grant_d = grant_sel;
                    adr_d        = sel_adr;
                    dat_d        = sel_dat;
                    bsel_d       = sel_bsel;
                    // Read and write together is illegal Avalon; treat it as a write.
                    wr_d         = sel_wr;
                    rd_d         = sel_rd & ~sel_wr;
                    cnt_d        = '0;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (rd_q) begin
                        if (grant_q) begin
                            rdata1_d  = resp_data;
                            rvalid1_d = 1'b1;
                        end else begin
                            rdata0_d  = resp_data;
                            rvalid0_d = 1'b1;
                        end
                    end
                    if (failed) begin
                        err_d     = 1'b1;
                        err_src_d = grant_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            bsel_q       <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            cnt_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            err_q        <= 1'b0;
            err_src_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            bsel_q       <= bsel_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            err_q        <= err_d;
            err_src_q    <= err_src_d;
        end
    end

    assign adr_o            = adr_q;
    assign dat_o            = dat_q;
    assign bsel_o           = bsel_q;
    assign rd_o             = rd_q;
    assign wr_o             = wr_q;
    assign busy_o           = (state_q == BUSY);
    assign err_o            = err_q;
    assign err_src_o        = err_src_q;
    assign m0_readdata      = rdata0_q;
    assign m0_readdatavalid = rvalid0_q;
    assign m1_readdata      = rdata1_q;
    assign m1_readdatavalid = rvalid1_q;

endmodule

// File: tb/tb_bel_fft_sif_arb.sv
// Bench for bel_fft_sif_arb: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_bel_fft_sif_arb;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BC = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [1:0]          m_rd, m_wr;
    logic [1:0][AW-1:0]  m_adr;
    logic [1:0][DW-1:0]  m_wd;
    logic [1:0][BC-1:0]  m_be;
    logic [DW-1:0]       dat_i;
    logic                ack_i, err_i;

    logic                m0_wait, m1_wait, m0_rv, m1_rv;
    logic [DW-1:0]       m0_rdata, m1_rdata;
    logic [AW-1:0]       adr_o;
    logic [DW-1:0]       dat_o;
    logic [BC-1:0]       bsel_o;
    logic                rd_o, wr_o, busy_o, err_o, err_src_o;
    logic [1:0]          dut_wait;
    assign dut_wait = {m1_wait, m0_wait};

    bel_fft_sif_arb #(.AWIDTH(AW), .DWIDTH(DW), .BCNT(BC), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_address(m_adr[0]), .m0_writedata(m_wd[0]), .m0_byteenable(m_be[0]),
        .m0_read(m_rd[0]), .m0_write(m_wr[0]), .m0_waitrequest(m0_wait),
        .m0_readdata(m0_rdata), .m0_readdatavalid(m0_rv),
        .m1_address(m_adr[1]), .m1_writedata(m_wd[1]), .m1_byteenable(m_be[1]),
        .m1_read(m_rd[1]), .m1_write(m_wr[1]), .m1_waitrequest(m1_wait),
        .m1_readdata(m1_rdata), .m1_readdatavalid(m1_rv),
        .adr_o(adr_o), .dat_o(dat_o), .bsel_o(bsel_o), .rd_o(rd_o), .wr_o(wr_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i),
        .busy_o(busy_o), .err_o(err_o), .err_src_o(err_src_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: one outstanding access record plus response state.
    bit            mv = 1'b0;
    bit            m_busy;
    int            m_g, m_last, m_age;
    bit            m_iswr;
    logic [AW-1:0] m_a;
    logic [DW-1:0] m_d;
    logic [BC-1:0] m_b;
    logic [DW-1:0] e_rdata [2];
    bit            e_rv [2];
    bit            e_err, e_src;
    bit            acc [2];
    int            wait_cnt [2];
    int            max_wait = 0;

    always @(negedge clk) begin : model_p
        logic [1:0] req;
        logic [1:0] exp_wait;
        int         win;
        bit         done, fail;
        req = m_rd | m_wr;
        win = (req == 2'b11) ? (1 - m_last) : (req[1] ? 1 : 0);
        for (int n = 0; n < 2; n++)
            exp_wait[n] = req[n] && !(!m_busy && win == n);
        if (mv) begin
            check("m0_waitrequest", m0_wait, exp_wait[0]);
            check("m1_waitrequest", m1_wait, exp_wait[1]);
            check("rd_o", rd_o, m_busy && !m_iswr);
            check("wr_o", wr_o, m_busy && m_iswr);
            check("busy_o", busy_o, m_busy);
            if (m_busy) begin
                check("adr_o", adr_o, m_a);
                check("dat_o", dat_o, m_d);
                check("bsel_o", bsel_o, m_b);
            end
            check("m0_readdatavalid", m0_rv, e_rv[0]);
            check("m1_readdatavalid", m1_rv, e_rv[1]);
            check("m0_readdata", m0_rdata, e_rdata[0]);
            check("m1_readdata", m1_rdata, e_rdata[1]);
            check("err_o", err_o, e_err);
            check("err_src_o", err_src_o, e_src);
            for (int n = 0; n < 2; n++) begin
                wait_cnt[n] = (req[n] && exp_wait[n] && !rst) ? wait_cnt[n] + 1 : 0;
                if (wait_cnt[n] > max_wait) max_wait = wait_cnt[n];
            end
        end
        for (int n = 0; n < 2; n++)
            acc[n] = req[n] && !m_busy && (win == n) && !rst;

        if (rst) begin
            mv = 1'b1;
            m_busy = 1'b0;
            m_last = 1;
            e_rdata[0] = '0;
            e_rdata[1] = '0;
            e_rv[0] = 1'b0;
            e_rv[1] = 1'b0;
            e_err = 1'b0;
            e_src = 1'b0;
            wait_cnt[0] = 0;
            wait_cnt[1] = 0;
        end else if (mv) begin
            e_rv[0] = 1'b0;
            e_rv[1] = 1'b0;
            e_err = 1'b0;
            if (!m_busy) begin
                if (req != 2'b00) begin
                    m_busy = 1'b1;
                    m_g    = win;
                    m_last = win;
                    m_iswr = m_wr[win];
                    m_a    = m_adr[win];
                    m_d    = m_wd[win];
                    m_b    = m_be[win];
                    m_age  = 0;
                end
            end else begin
                done = err_i || ack_i || (m_age == TO - 1);
                fail = err_i || !ack_i;
                if (done) begin
                    if (!m_iswr) begin
                        e_rdata[m_g] = fail ? {DW{1'b1}} : dat_i;
                        e_rv[m_g]    = 1'b1;
                    end
                    if (fail) begin
                        e_err = 1'b1;
                        e_src = m_g[0];
                    end
                    m_busy = 1'b0;
                end else begin
                    m_age++;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m_rd = '0; m_wr = '0; ack_i = 1'b0; err_i = 1'b0;
    endtask

    task automatic do_reset;
        tick; idle_inputs; rst = 1'b1;
        tick; tick; rst = 1'b0;
    endtask

    task automatic solo_write(input int n);
        tick; m_wr[n] = 1'b1; m_adr[n] = 8'h70; m_wd[n] = 32'h0000_0070; m_be[n] = 4'hF;
        at_neg;
        tick; m_wr[n] = 1'b0; ack_i = 1'b1;
        at_neg;
        tick; ack_i = 1'b0;
        at_neg;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int first;
        int op;
        rst = 1'b1;
        m_rd = '0; m_wr = '0; m_adr = '0; m_wd = '0; m_be = '0;
        dat_i = '0; ack_i = 1'b0; err_i = 1'b0;

        // Reset state.
        do_reset;
        at_neg;
        check("rst rd_o", rd_o, 0);
        check("rst wr_o", wr_o, 0);
        check("rst busy_o", busy_o, 0);
        check("rst err_o", err_o, 0);
        check("rst adr_o", adr_o, 0);
        check("rst m0_readdata", m0_rdata, 0);
        check("rst m0_waitrequest", m0_wait, 0);

        // Single m0 read with immediate ack.
        tick; m_rd[0] = 1'b1; m_adr[0] = 8'h10;
        at_neg; check("t1 m0_wait T0", m0_wait, 0);
        tick; m_rd[0] = 1'b0; ack_i = 1'b1; dat_i = 32'hA5A5_0001;
        at_neg; check("t1 rd_o T1", rd_o, 1); check("t1 adr_o T1", adr_o, 8'h10); check("t1 busy T1", busy_o, 1);
        tick; ack_i = 1'b0; dat_i = '0;
        at_neg;
        check("t1 rd_o T2", rd_o, 0);
        check("t1 m0_rv T2", m0_rv, 1);
        check("t1 m0_rdata T2", m0_rdata, 32'hA5A5_0001);
        check("t1 m1_rv T2", m1_rv, 0);
        check("t1 m1_rdata T2", m1_rdata, 0);
        tick;
        at_neg; check("t1 m0_rv T3", m0_rv, 0); check("t1 m0_rdata hold", m0_rdata, 32'hA5A5_0001);

        // Simultaneous requests after reset: m0 first, m1 accepted at T2.
        do_reset;
        tick;
        m_wr[0] = 1'b1; m_adr[0] = 8'h04; m_wd[0] = 32'h0000_1234; m_be[0] = 4'hF;
        m_rd[1] = 1'b1; m_adr[1] = 8'h08;
        at_neg; check("t2 m0_wait T0", m0_wait, 0); check("t2 m1_wait T0", m1_wait, 1);
        tick; m_wr[0] = 1'b0; ack_i = 1'b1;
        at_neg;
        check("t2 wr_o T1", wr_o, 1); check("t2 adr_o T1", adr_o, 8'h04);
        check("t2 dat_o T1", dat_o, 32'h1234); check("t2 m1_wait T1", m1_wait, 1);
        tick; ack_i = 1'b0;
        at_neg; check("t2 m1_wait T2", m1_wait, 0); check("t2 wr_o T2", wr_o, 0);
        tick; m_rd[1] = 1'b0; ack_i = 1'b1; dat_i = 32'hBEEF_0008;
        at_neg; check("t2 rd_o T3", rd_o, 1); check("t2 adr_o T3", adr_o, 8'h08);
        tick; ack_i = 1'b0;
        at_neg; check("t2 m1_rv T4", m1_rv, 1); check("t2 m1_rdata T4", m1_rdata, 32'hBEEF_0008);

        // Tie-breaking alternates with whoever was served last.
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 1) solo_write(0);
            else if (k > 0) solo_write(1);
            first = (k % 2 == 1) ? 1 : 0;
            tick;
            m_wr = 2'b11; m_adr[0] = 8'h80; m_adr[1] = 8'h81;
            at_neg;
            check("tie winner wait", dut_wait[first], 0);
            check("tie loser wait", dut_wait[1-first], 1);
            tick; m_wr[first] = 1'b0; ack_i = 1'b1;
            at_neg;
            tick; ack_i = 1'b0;
            at_neg; check("tie loser accepted", dut_wait[1-first], 0);
            tick; m_wr[1-first] = 1'b0; ack_i = 1'b1;
            at_neg;
            tick; ack_i = 1'b0;
            at_neg;
        end

        // m1 read with ack delayed 5 cycles; m0 stalls throughout.
        tick; m_rd[1] = 1'b1; m_adr[1] = 8'h3C;
        at_neg; check("t3 m1_wait T0", m1_wait, 0);
        tick; m_rd[1] = 1'b0; m_wr[0] = 1'b1; m_adr[0] = 8'h20; m_wd[0] = 32'h0000_0020;
        for (int i = 0; i < 5; i++) begin
            at_neg;
            check("t3 rd_o held", rd_o, 1); check("t3 adr_o held", adr_o, 8'h3C);
            check("t3 busy_o", busy_o, 1); check("t3 m0_wait", m0_wait, 1);
            tick;
        end
        ack_i = 1'b1; dat_i = 32'hC0DE_0003;
        at_neg; check("t3 m0_wait ack", m0_wait, 1); check("t3 rv before", m1_rv, 0);
        tick; ack_i = 1'b0;
        at_neg;
        check("t3 m1_rv", m1_rv, 1); check("t3 m1_rdata", m1_rdata, 32'hC0DE_0003);
        check("t3 m0 accepted", m0_wait, 0);
        tick; m_wr[0] = 1'b0; ack_i = 1'b1;
        at_neg; check("t3 wr_o", wr_o, 1); check("t3 wr adr_o", adr_o, 8'h20);
        tick; ack_i = 1'b0;
        at_neg; check("t3 busy done", busy_o, 0);

        // Timeout: m0 read never acknowledged.
        tick; m_rd[0] = 1'b1; m_adr[0] = 8'h44;
        at_neg; check("t4 m0_wait T0", m0_wait, 0);
        tick; m_rd[0] = 1'b0;
        for (int i = 0; i < TO; i++) begin
            at_neg; check("t4 rd_o busy", rd_o, 1); check("t4 no err yet", err_o, 0);
            tick;
        end
        at_neg;
        check("t4 rd_o done", rd_o, 0); check("t4 m0_rv", m0_rv, 1);
        check("t4 m0_rdata", m0_rdata, 32'hFFFF_FFFF); check("t4 err_o", err_o, 1);
        check("t4 err_src_o", err_src_o, 0); check("t4 busy_o", busy_o, 0);
        tick;
        at_neg; check("t4 err_o pulse", err_o, 0); check("t4 rv pulse", m0_rv, 0);

        // err_i and ack_i together on an m1 read.
        tick; m_rd[1] = 1'b1; m_adr[1] = 8'h50;
        at_neg; check("t5 m1_wait", m1_wait, 0);
        tick; m_rd[1] = 1'b0; ack_i = 1'b1; err_i = 1'b1; dat_i = 32'h1234_5678;
        at_neg; check("t5 rd_o", rd_o, 1);
        tick; ack_i = 1'b0; err_i = 1'b0;
        at_neg;
        check("t5 m1_rv", m1_rv, 1); check("t5 m1_rdata", m1_rdata, 32'hFFFF_FFFF);
        check("t5 err_o", err_o, 1); check("t5 err_src_o", err_src_o, 1);

        // Reset in BUSY with an ack pending.
        tick; m_rd[0] = 1'b1; m_adr[0] = 8'h60;
        at_neg; check("t6 m0_wait", m0_wait, 0);
        tick; m_rd[0] = 1'b0; rst = 1'b1; ack_i = 1'b1; dat_i = 32'h6666_6666;
        at_neg; check("t6 rd_o before rst", rd_o, 1);
        tick; rst = 1'b0; ack_i = 1'b0; m_rd = 2'b11; m_adr[0] = 8'h61; m_adr[1] = 8'h62;
        at_neg;
        check("t6 rd_o after rst", rd_o, 0); check("t6 busy after rst", busy_o, 0);
        check("t6 no m0_rv", m0_rv, 0); check("t6 m0_rdata cleared", m0_rdata, 0);
        check("t6 m0 wins", m0_wait, 0); check("t6 m1 waits", m1_wait, 1);
        tick; m_rd[0] = 1'b0; ack_i = 1'b1;
        at_neg;
        tick; ack_i = 1'b0;
        at_neg;
        tick; m_rd[1] = 1'b0; ack_i = 1'b1;
        at_neg;
        tick; idle_inputs;
        at_neg;

        // Randomized traffic, checked every cycle by the model.
        for (int c = 0; c < 4000; c++) begin
            tick;
            rst = ($urandom_range(0, 399) == 0);
            for (int n = 0; n < 2; n++) begin
                if (rst) begin
                    m_rd[n] = 1'b0; m_wr[n] = 1'b0;
                end else if ((m_rd[n] || m_wr[n]) && !acc[n]) begin
                    // Avalon master holds its request until accepted.
                end else if ($urandom_range(0, 99) < 45) begin
                    op = $urandom_range(0, 9);
                    m_rd[n]  = (op <= 4) || (op == 9);
                    m_wr[n]  = (op >= 5);
                    m_adr[n] = AW'($urandom);
                    m_wd[n]  = $urandom;
                    m_be[n]  = BC'($urandom);
                end else begin
                    m_rd[n] = 1'b0; m_wr[n] = 1'b0;
                end
            end
            ack_i = ($urandom_range(0, 99) < 30);
            err_i = ($urandom_range(0, 99) < 6);
            dat_i = $urandom;
        end
        tick; idle_inputs; rst = 1'b0;
        repeat (12) tick;
        at_neg;
        check("no starvation (max wait <= 20)", max_wait > 20, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
